// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader
//   Read-side consumer for the dual-clock fifo, running entirely in the
//   fifo's read clock domain. It pops bytes from the fifo read port and
//   emits framed packets on a valid/ready stream. Each frame is a HEADER
//   beat, then FRAME_LEN payload beats, then an XOR checksum beat.
//   An empty fifo mid-frame inserts bubbles; nothing is popped unless the
//   popped byte can be registered on the same edge.
module fifo_frame_reader #(
    parameter int                  DATASIZE  = 8,
    parameter int                  FRAME_LEN = 16,
    parameter logic [DATASIZE-1:0] HEADER    = DATASIZE'(8'hA5)
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                enable,
    input  logic [DATASIZE-1:0] rdata,
    input  logic                rempty,
    output logic                rinc,
    output logic [DATASIZE-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_sof,
    output logic                m_eof,
    output logic [15:0]         frame_cnt
);

    // Payload index must reach FRAME_LEN-1 for any FRAME_LEN in 1..256.
    localparam int               IDX_W    = $clog2(FRAME_LEN) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [DATASIZE-1:0] m_data_q,    m_data_d;
    logic                m_valid_q,   m_valid_d;
    logic                m_sof_q,     m_sof_d;
    logic                m_eof_q,     m_eof_d;
    logic [DATASIZE-1:0] csum_q,      csum_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    // The output register may load a new beat when empty or being consumed.
    logic adv;

    // State register: every register clears on a synchronous active-low reset.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q     <= S_IDLE;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_sof_q     <= 1'b0;
            m_eof_q     <= 1'b0;
            csum_q      <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_sof_q     <= m_sof_d;
            m_eof_q     <= m_eof_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state and next-beat logic; nothing moves while a beat is stalled.
    always_comb begin
        state_d     = state_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_sof_d     = m_sof_q;
        m_eof_d     = m_eof_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;

        if (adv) begin
            case (state_q)
                S_IDLE: begin
                    // A frame only starts when its first payload byte is already
                    // waiting, so an idle fifo never produces a lone header.
                    if (enable && !rempty) begin
                        m_data_d  = HEADER;
                        m_sof_d   = 1'b1;
                        m_eof_d   = 1'b0;
                        m_valid_d = 1'b1;
                        csum_d    = '0;
                        idx_d     = '0;
                        state_d   = S_PAYLOAD;
                    end else begin
                        m_valid_d = 1'b0;
                    end
                end
                S_PAYLOAD: begin
                    if (!rempty) begin
                        m_data_d  = rdata;
                        m_valid_d = 1'b1;
                        m_sof_d   = 1'b0;
                        csum_d    = csum_q ^ rdata;
                        idx_d     = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        // Underflow: emit a bubble and wait for the fifo.
                        m_valid_d = 1'b0;
                    end
                end
                S_CHECK: begin
                    m_data_d    = csum_q;
                    m_eof_d     = 1'b1;
                    m_valid_d   = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d   = S_IDLE;
                    m_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Output logic: advance condition and the fifo pop, the sole pop source.
    always_comb begin
        adv  = !m_valid_q || m_ready;
        rinc = rrst_n && adv && (state_q == S_PAYLOAD) && !rempty;
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_sof     = m_sof_q;
    assign m_eof     = m_eof_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Testbench for fifo_frame_reader: a queue stands in for the fifo, and the
// accepted stream is checked frame by frame against the popped bytes.
module tb_fifo_frame_reader;

    localparam int         FL  = 16;
    localparam logic [7:0] HDR = 8'hA5;

    logic        rclk = 1'b0;
    logic        rrst_n, enable, rempty, rinc, m_valid, m_ready, m_sof, m_eof;
    logic [7:0]  rdata, m_data;
    logic [15:0] frame_cnt;

    always #5 rclk = ~rclk;

    fifo_frame_reader #(.DATASIZE(8), .FRAME_LEN(FL), .HEADER(HDR)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .enable    (enable),
        .rdata     (rdata),
        .rempty    (rempty),
        .rinc      (rinc),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sof     (m_sof),
        .m_eof     (m_eof),
        .frame_cnt (frame_cnt)
    );

    int total = 0;
    int passed = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] popped[$];
    bit         gap = 1'b0;

    logic        s_valid, s_sof, s_eof, s_rinc, s_rst, s_ready;
    logic [7:0]  s_data;
    logic [15:0] s_cnt;
    logic        p_valid, p_sof, p_eof, p_ready, p_rst;
    logic [7:0]  p_data;
    bit          have_prev = 1'b0;

    int         pos = 0, pops_in_frame = 0, frames_done = 0, frames_since_rst = 0;
    int         run = 0, last_run = 0, n = 0;
    logic [7:0] xacc = 8'h00, last_csum = 8'h00, first_payload = 8'h00, exp_cs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One accepted beat: header, payload in pop order, then XOR of the payload.
    task automatic accept_beat();
        logic [7:0] e;
        if (pos == 0) begin
            check("hdr_data", 32'(s_data), 32'(HDR));
            check("hdr_sof", 32'(s_sof), 32'd1);
            check("hdr_eof", 32'(s_eof), 32'd0);
            xacc = 8'h00;
        end else if (pos <= FL) begin
            check("pay_avail", 32'(popped.size() != 0), 32'd1);
            if (popped.size() != 0) begin
                e = popped.pop_front();
                check("pay_data", 32'(s_data), 32'(e));
                xacc ^= e;
            end
            if (pos == 1) first_payload = s_data;
            check("pay_flags", 32'({s_sof, s_eof}), 32'd0);
        end else begin
            check("csum_data", 32'(s_data), 32'(xacc));
            check("csum_flags", 32'({s_sof, s_eof}), 32'd1);
            check("pops_per_frame", 32'(pops_in_frame), 32'(FL));
            pops_in_frame = 0;
            last_csum = s_data;
            last_run = run;
            frames_done++;
            frames_since_rst++;
        end
        pos = (pos == FL + 1) ? 0 : pos + 1;
    endtask

    // One clock: drive the fifo side, sample at negedge, update model at posedge.
    task automatic cycle();
        rempty = gap || (fifo_q.size() == 0);
        rdata  = rempty ? 8'($urandom) : fifo_q[0];
        @(negedge rclk);
        s_valid = m_valid; s_sof = m_sof; s_eof = m_eof; s_data = m_data;
        s_rinc = rinc; s_rst = rrst_n; s_ready = m_ready; s_cnt = frame_cnt;
        check("rinc_legal",
              32'(s_rinc && !(s_rst && !rempty && (!s_valid || s_ready))), 32'd0);
        if (have_prev && p_rst && p_valid && !p_ready)
            check("hold_stable", 32'({s_valid, s_sof, s_eof, s_data}),
                  32'({p_valid, p_sof, p_eof, p_data}));
        if (s_valid && s_sof) run = 1;
        else if (s_valid) run++;
        else run = 0;
        @(posedge rclk);
        if (!s_rst) begin
            popped.delete();
            pos = 0; xacc = 8'h00; pops_in_frame = 0; frames_since_rst = 0;
        end else begin
            if (s_rinc && fifo_q.size() != 0) begin
                popped.push_back(fifo_q.pop_front());
                pops_in_frame++;
            end
            if (s_valid && s_ready) accept_beat();
        end
        have_prev = 1'b1;
        p_valid = s_valid; p_sof = s_sof; p_eof = s_eof; p_data = s_data;
        p_ready = s_ready; p_rst = s_rst;
        #1;
    endtask

    initial begin
        rrst_n = 1'b0; enable = 1'b1; m_ready = 1'b1; rempty = 1'b1; rdata = 8'h00;
        for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
        @(posedge rclk); #1;

        // 1: reset with data present and enable high
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_valid", 32'(s_valid), 32'd0);
            check("rst_rinc", 32'(s_rinc), 32'd0);
            check("rst_cnt", 32'(s_cnt), 32'd0);
        end
        check("rst_nopop", 32'(fifo_q.size()), 32'd16);

        // 2: full rate
        rrst_n = 1'b1;
        n = 0;
        while (frames_done < 1 && n < 200) begin cycle(); n++; end
        check("t2_done", 32'(frames_done), 32'd1);
        check("t2_csum", 32'(last_csum), 32'h10);
        check("t2_beats_consecutive", 32'(last_run), 32'(FL + 2));
        check("t2_drained", 32'(fifo_q.size()), 32'd0);
        cycle(); cycle();
        check("t2_frame_cnt", 32'(s_cnt), 32'd1);
        check("t2_idle", 32'(s_valid), 32'd0);

        // 3: backpressure, m_ready alternating
        for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
        n = 0;
        while (frames_done < 2 && n < 200) begin m_ready = (n % 2 == 0); cycle(); n++; end
        m_ready = 1'b1;
        check("t3_done", 32'(frames_done), 32'd2);
        check("t3_csum", 32'(last_csum), 32'h10);
        check("t3_drained", 32'(fifo_q.size()), 32'd0);

        // 4: underflow after five payload bytes
        for (int i = 1; i <= 5; i++) fifo_q.push_back(8'(i));
        n = 0;
        while (fifo_q.size() != 0 && n < 100) begin cycle(); n++; end
        check("t4_first5_popped", 32'(fifo_q.size()), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t4_gap_rinc", 32'(s_rinc), 32'd0);
            if (i > 0) check("t4_gap_valid", 32'(s_valid), 32'd0);
        end
        for (int i = 6; i <= 16; i++) fifo_q.push_back(8'(i));
        n = 0;
        while (frames_done < 3 && n < 200) begin cycle(); n++; end
        check("t4_done", 32'(frames_done), 32'd3);
        check("t4_csum", 32'(last_csum), 32'h10);

        // 5: enable dropped after header; frame still completes
        for (int i = 0; i < 32; i++) fifo_q.push_back(8'($urandom));
        n = 0;
        while (!(s_valid && s_sof) && n < 50) begin cycle(); n++; end
        check("t5_hdr_seen", 32'(s_valid && s_sof), 32'd1);
        enable = 1'b0;
        n = 0;
        while (frames_done < 4 && n < 200) begin cycle(); n++; end
        check("t5_done", 32'(frames_done), 32'd4);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t5_disabled_valid", 32'(s_valid), 32'd0);
            check("t5_disabled_rinc", 32'(s_rinc), 32'd0);
        end
        check("t5_data_waiting", 32'(fifo_q.size()), 32'd16);
        enable = 1'b1;
        cycle();
        check("t5_not_yet", 32'(s_valid), 32'd0);
        cycle();
        check("t5_hdr_next", 32'({s_valid, s_sof, s_data}), 32'({2'b11, HDR}));
        enable = 1'b0;
        n = 0;
        while (frames_done < 5 && n < 200) begin cycle(); n++; end
        check("t5_done2", 32'(frames_done), 32'd5);

        // 6: reset mid-frame after eight payload beats
        enable = 1'b1;
        for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
        n = 0;
        while (!(s_valid && !s_sof && s_data == 8'h07) && n < 50) begin cycle(); n++; end
        check("t6_reached_07", 32'(s_data), 32'h07);
        rrst_n = 1'b0;
        cycle();
        check("t6_rst_rinc", 32'(s_rinc), 32'd0);
        cycle();
        check("t6_rst_valid", 32'(s_valid), 32'd0);
        check("t6_rst_cnt", 32'(s_cnt), 32'd0);
        check("t6_eight_popped", 32'(fifo_q.size()), 32'd8);
        rrst_n = 1'b1;
        for (int i = 17; i <= 24; i++) fifo_q.push_back(8'(i));
        exp_cs = 8'h00;
        for (int i = 9; i <= 24; i++) exp_cs ^= 8'(i);
        n = 0;
        while (frames_done < 6 && n < 200) begin cycle(); n++; end
        check("t6_done", 32'(frames_done), 32'd6);
        check("t6_first_payload", 32'(first_payload), 32'h09);
        check("t6_csum", 32'(last_csum), 32'(exp_cs));
        cycle(); cycle();
        check("t6_frame_cnt", 32'(s_cnt), 32'd1);

        // 7: random data, ready, enable and fifo gaps
        for (int i = 0; i < 64; i++) fifo_q.push_back(8'($urandom));
        n = 0;
        while (frames_done < 10 && n < 3000) begin
            m_ready = ($urandom_range(0, 3) != 0);
            gap     = ($urandom_range(0, 4) == 0);
            enable  = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
        end
        gap = 1'b0; m_ready = 1'b1; enable = 1'b1;
        check("t7_done", 32'(frames_done), 32'd10);
        check("t7_drained", 32'(fifo_q.size()), 32'd0);
        cycle(); cycle();
        check("t7_frame_cnt", 32'(s_cnt), 32'(frames_since_rst));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
